// File: rtl/snake_pkg.sv
// snake_pkg: direction encodings, PS/2 scan codes and the key-to-direction map
package snake_pkg;
  localparam logic [2:0] DIR_UP    = 3'b000;
  localparam logic [2:0] DIR_LEFT  = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_RIGHT = 3'b011;
  localparam logic [2:0] DIR_NONE  = 3'b111;
  localparam logic [7:0] SC_E0    = 8'hE0;
  localparam logic [7:0] SC_F0    = 8'hF0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  function automatic logic [2:0] dir_map(input logic [7:0] code, input logic ext);
    return ext ? (code == SC_UP   ? DIR_UP   : code == SC_LEFT ? DIR_LEFT :
                  code == SC_DOWN ? DIR_DOWN : code == SC_RIGHT ? DIR_RIGHT : DIR_NONE)
               : (code == SC_W ? DIR_UP   : code == SC_A ? DIR_LEFT :
                  code == SC_S ? DIR_DOWN : code == SC_D ? DIR_RIGHT : DIR_NONE);
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: synchronises the PS/2 pins and flags falling edges of the keyboard clock
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic reset,
  input  logic PS2_CLK,
  input  logic PS2_DAT,
  output logic sync_dat,
  output logic fall
);
  logic [SYNC_STAGES-1:0] clk_sh, dat_sh;
  logic prev_clk;
  assign sync_dat = dat_sh[SYNC_STAGES-1];
  assign fall = prev_clk & ~clk_sh[SYNC_STAGES-1];
  // shift pins through the synchroniser, idle-high out of reset
  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_sh <= '1;
      dat_sh <= '1;
      prev_clk <= 1'b1;
    end else begin
      clk_sh <= {clk_sh[SYNC_STAGES-2:0], PS2_CLK};
      dat_sh <= {dat_sh[SYNC_STAGES-2:0], PS2_DAT};
      prev_clk <= clk_sh[SYNC_STAGES-1];
    end
  end
endmodule

// File: rtl/ps2_dir_decoder.sv
// ps2_dir_decoder: PS/2 frame receiver with E0/F0 prefix tracking and snake direction map
module ps2_dir_decoder
  import snake_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [2:0] dir,
  output logic       dir_strobe,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  logic sync_dat, fall, ext, brk, timeout, frame_ok;
  logic [1:0] state;
  logic [3:0] bit_cnt;
  logic [9:0] sh;
  logic [TW-1:0] idle_cnt;
  logic [2:0] map_dir;
  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CLK(CLK),
    .reset(reset),
    .PS2_CLK(PS2_CLK),
    .PS2_DAT(PS2_DAT),
    .sync_dat(sync_dat),
    .fall(fall)
  );
  assign timeout = idle_cnt == TW'(TIMEOUT_CYC - 1);
  assign frame_ok = (^sh[8:0]) & sh[9];
  assign map_dir = dir_map(sh[7:0], ext);
  // receive FSM: start bit, 8 data + parity + stop shifted in LSB first, then one check cycle
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      idle_cnt <= '0;
      ext <= 1'b0;
      brk <= 1'b0;
      dir <= DIR_NONE;
      dir_strobe <= 1'b0;
      key_code <= '0;
      key_ext <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dir_strobe <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        idle_cnt <= '0;
        if (fall && sync_dat) frame_err <= 1'b1;
        else if (fall) begin
          bit_cnt <= '0;
          state <= RECV;
        end
      end else if (state == RECV) begin
        if (timeout) begin
          frame_err <= 1'b1;
          state <= IDLE;
        end else if (fall) begin
          idle_cnt <= '0;
          sh <= {sync_dat, sh[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
          state <= bit_cnt == 4'd9 ? CHECK : RECV;
        end else idle_cnt <= idle_cnt + TW'(1);
      end else begin
        state <= IDLE;
        if (!frame_ok) frame_err <= 1'b1;
        else if (sh[7:0] == SC_E0) ext <= 1'b1;
        else if (sh[7:0] == SC_F0) brk <= 1'b1;
        else begin
          key_code <= sh[7:0];
          key_ext <= ext;
          key_break <= brk;
          key_valid <= 1'b1;
          ext <= 1'b0;
          brk <= 1'b0;
          if (!brk && map_dir != DIR_NONE) begin
            dir <= map_dir;
            dir_strobe <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_dir_decoder.sv
// tb_ps2_dir_decoder: directed PS/2 frames with hand-computed expected decode results
module tb_ps2_dir_decoder;
  localparam int T = 100;
  localparam int H = 20;
  logic CLK = 1'b0, reset = 1'b1, PS2_CLK = 1'b1, PS2_DAT = 1'b1;
  logic [2:0] dir;
  logic [7:0] key_code;
  logic dir_strobe, key_ext, key_break, key_valid, frame_err;
  int n_chk = 0, n_bad = 0;
  int n_kv = 0, n_ds = 0, n_fe = 0;
  int kv0, ds0, fe0, lat, slat, tcnt;
  ps2_dir_decoder #(.TIMEOUT_CYC(T), .SYNC_STAGES(2)) dut (
    .CLK(CLK),
    .reset(reset),
    .PS2_CLK(PS2_CLK),
    .PS2_DAT(PS2_DAT),
    .dir(dir),
    .dir_strobe(dir_strobe),
    .key_code(key_code),
    .key_ext(key_ext),
    .key_break(key_break),
    .key_valid(key_valid),
    .frame_err(frame_err)
  );
  always #5 CLK = ~CLK;
  // tally every output pulse
  always @(negedge CLK) begin
    if (!reset) begin
      n_kv <= n_kv + int'(key_valid);
      n_ds <= n_ds + int'(dir_strobe);
      n_fe <= n_fe + int'(frame_err);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic snap();
    kv0 = n_kv;
    ds0 = n_ds;
    fe0 = n_fe;
  endtask
  task automatic ps2_bit(input logic b);
    @(negedge CLK);
    PS2_DAT = b;
    repeat (H) @(negedge CLK);
    PS2_CLK = 1'b0;
    for (int i = 1; i <= H; i++) begin
      @(posedge CLK);
      #1;
      if ((key_valid || frame_err) && lat < 0) lat = i;
      if (dir_strobe && slat < 0) slat = i;
    end
    @(negedge CLK);
    PS2_CLK = 1'b1;
  endtask
  task automatic send_frame(input logic [7:0] code, input logic flip = 1'b0);
    lat = -1;
    slat = -1;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(~^code ^ flip);
    ps2_bit(1'b1);
    repeat (2 * H) @(negedge CLK);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (4) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    check("rst_dir", dir, 3'b111);
    check("rst_code", key_code, 8'h00);
    check("rst_ext", key_ext, 0);
    check("rst_brk", key_break, 0);
    check("rst_pulses", {key_valid, dir_strobe, frame_err}, 0);
    snap();
    send_frame(8'h1D);
    check("t1_lat", lat, 4);
    check("t1_slat", slat, 4);
    check("t1_code", key_code, 8'h1D);
    check("t1_extbrk", {key_ext, key_break}, 0);
    check("t1_dir", dir, 3'b000);
    check("t1_kv", n_kv - kv0, 1);
    check("t1_ds", n_ds - ds0, 1);
    snap();
    send_frame(8'hE0);
    send_frame(8'h74);
    check("t2_kv", n_kv - kv0, 1);
    check("t2_ds", n_ds - ds0, 1);
    check("t2_code", key_code, 8'h74);
    check("t2_ext", key_ext, 1);
    check("t2_dir", dir, 3'b011);
    snap();
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h74);
    check("t2b_kv", n_kv - kv0, 1);
    check("t2b_ds", n_ds - ds0, 0);
    check("t2b_extbrk", {key_ext, key_break}, 2'b11);
    check("t2b_dir", dir, 3'b011);
    snap();
    send_frame(8'h1C, 1'b1);
    check("t3_fe", n_fe - fe0, 1);
    check("t3_kv", n_kv - kv0, 0);
    check("t3_dir", dir, 3'b011);
    send_frame(8'h1B);
    check("t3_code", key_code, 8'h1B);
    check("t3_dir2", dir, 3'b010);
    snap();
    lat = -1;
    ps2_bit(1'b1);
    repeat (H) @(negedge CLK);
    check("bad_start_fe", n_fe - fe0, 1);
    check("bad_start_kv", n_kv - kv0, 0);
    snap();
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    @(negedge CLK);
    PS2_DAT = 1'b0;
    repeat (H) @(negedge CLK);
    PS2_CLK = 1'b0;
    tcnt = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge CLK);
      #1;
      if (frame_err && tcnt < 0) tcnt = i;
      if (i == H) PS2_CLK = 1'b1;
    end
    check("t4_timeout_cyc", tcnt, T + 3);
    check("t4_fe", n_fe - fe0, 1);
    check("t4_kv", n_kv - kv0, 0);
    send_frame(8'h23);
    check("t4_code", key_code, 8'h23);
    check("t4_dir", dir, 3'b011);
    snap();
    send_frame(8'hF0);
    send_frame(8'h1D);
    check("t5_code", key_code, 8'h1D);
    check("t5_brk", {key_ext, key_break}, 2'b01);
    check("t5_dir", dir, 3'b011);
    check("t5_ds", n_ds - ds0, 0);
    snap();
    send_frame(8'h15);
    check("t5b_kv", n_kv - kv0, 1);
    check("t5b_ds", n_ds - ds0, 0);
    check("t5b_code", key_code, 8'h15);
    check("t5b_brk", key_break, 0);
    check("t5b_dir", dir, 3'b011);
    send_frame(8'hE0);
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    @(negedge CLK);
    reset = 1'b1;
    repeat (2) @(negedge CLK);
    check("t6_rst_dir", dir, 3'b111);
    check("t6_rst_flags", {key_ext, key_break}, 0);
    reset = 1'b0;
    repeat (H) @(negedge CLK);
    snap();
    send_frame(8'h1D);
    check("t6_code", key_code, 8'h1D);
    check("t6_ext", key_ext, 0);
    check("t6_dir", dir, 3'b000);
    check("t6_ds", n_ds - ds0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_bad);
    $finish;
  end
endmodule
